// File: rtl/ppu_line_fetch_ctrl.sv
// Line fetch controller: streams one game-window line from the frame buffer
// into the back bank of a double-buffered line buffer while the display reads the front bank.
module ppu_line_fetch_ctrl #(
  parameter int LINE_W  = 256,
  parameter int ADDR_W  = 17,
  parameter int BASE    = 0,
  parameter int MAX_OUT = 4
) (
  input  logic                    hdmi_clk,
  input  logic                    rst,
  input  logic                    line_start,
  input  logic [8:0]              next_line,
  input  logic                    IsGameWindow,
  output logic                    mem_req,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  input  logic [15:0]             mem_rdata,
  output logic                    lb_we,
  output logic [$clog2(LINE_W):0] lb_waddr,
  output logic [15:0]             lb_wdata,
  output logic                    rd_bank,
  output logic                    busy,
  output logic                    underrun
);
  localparam int COL_W = $clog2(LINE_W);
  localparam int CNT_W = COL_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(LINE_W - 1);
  localparam logic [CNT_W-1:0] LINE_CNT  = CNT_W'(LINE_W);
  localparam logic [2:0]       MAX_OUT_C = 3'(MAX_OUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [8:0]       line_reg, line_next;
  logic [CNT_W-1:0] issued_reg, issued_next;
  logic [CNT_W-1:0] received_reg, received_next;
  logic [2:0]       outstanding_reg, outstanding_next;
  logic             wr_bank_reg, wr_bank_next;
  logic             rd_bank_reg, rd_bank_next;
  logic             line_ready_reg, line_ready_next;
  logic             underrun_reg, underrun_next;

  logic             start_ok;
  logic             fetching;
  logic             req;
  logic             grant;
  logic             wr;
  logic             swap;
  logic [ADDR_W-1:0] addr_sum;

  always_comb begin
    start_ok = line_start && IsGameWindow;
    fetching = (state_reg != IDLE);
    req      = (state_reg == FETCH) && (issued_reg < LINE_CNT) &&
               (outstanding_reg < MAX_OUT_C);
    grant    = req && mem_gnt;
    // Read data is written to the line buffer in the cycle it arrives.
    wr       = fetching && mem_rvalid;
    swap     = line_ready_reg;
    // Sum is taken modulo 2^ADDR_W so the last lines wrap to the buffer start.
    addr_sum = ADDR_W'(BASE) + ADDR_W'({line_reg, {COL_W{1'b0}}}) + ADDR_W'(issued_reg);
  end

  always_comb begin
    state_next       = state_reg;
    line_next        = line_reg;
    issued_next      = issued_reg;
    received_next    = received_reg;
    outstanding_next = outstanding_reg + {2'b00, grant} - {2'b00, wr};
    wr_bank_next     = wr_bank_reg;
    rd_bank_next     = rd_bank_reg;
    line_ready_next  = line_ready_reg;
    underrun_next    = start_ok && fetching;

    if (grant) begin
      issued_next = issued_reg + CNT_W'(1);
    end
    if (wr) begin
      received_next = received_reg + CNT_W'(1);
    end

    case (state_reg)
      IDLE: begin
        if (start_ok) begin
          rd_bank_next     = rd_bank_reg ^ swap;
          line_ready_next  = 1'b0;
          wr_bank_next     = ~(rd_bank_reg ^ swap);
          line_next        = next_line;
          issued_next      = '0;
          received_next    = '0;
          outstanding_next = '0;
          state_next       = FETCH;
        end
      end
      FETCH: begin
        if (grant && (issued_reg == LAST_IDX)) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        state_next = DRAIN;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // The last returned word completes the line from either active state.
    if (wr && (received_reg == LAST_IDX)) begin
      state_next      = IDLE;
      line_ready_next = 1'b1;
    end
  end

  always_ff @(posedge hdmi_clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      line_reg        <= '0;
      issued_reg      <= '0;
      received_reg    <= '0;
      outstanding_reg <= '0;
      wr_bank_reg     <= 1'b0;
      rd_bank_reg     <= 1'b0;
      line_ready_reg  <= 1'b0;
      underrun_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      line_reg        <= line_next;
      issued_reg      <= issued_next;
      received_reg    <= received_next;
      outstanding_reg <= outstanding_next;
      wr_bank_reg     <= wr_bank_next;
      rd_bank_reg     <= rd_bank_next;
      line_ready_reg  <= line_ready_next;
      underrun_reg    <= underrun_next;
    end
  end

  assign mem_req  = req;
  assign mem_addr = req ? addr_sum : '0;
  assign lb_we    = wr;
  assign lb_waddr = wr ? {wr_bank_reg, received_reg[COL_W-1:0]} : '0;
  assign lb_wdata = wr ? mem_rdata : '0;
  assign rd_bank  = rd_bank_reg;
  assign busy     = fetching;
  assign underrun = underrun_reg;

endmodule

// File: tb/tb_ppu_line_fetch_ctrl.sv
// Bench for ppu_line_fetch_ctrl: a line-level table drives a randomized memory
// model; a transaction-count reference model checks every cycle on two base addresses.
module tb_ppu_line_fetch_ctrl;
  localparam int LINE_W  = 256;
  localparam int ADDR_W  = 17;
  localparam int MAX_OUT = 4;
  localparam int BASE_A  = 0;
  localparam int BASE_B  = 'h1FF00;

  logic hdmi_clk = 1'b0;
  always #5 hdmi_clk = ~hdmi_clk;

  logic        rst, line_start, IsGameWindow, mem_gnt, mem_rvalid;
  logic [8:0]  next_line;
  logic [15:0] mem_rdata;
  logic        mem_req_a, mem_req_b, lb_we_a, lb_we_b;
  logic [16:0] mem_addr_a, mem_addr_b;
  logic [8:0]  lb_waddr_a, lb_waddr_b;
  logic [15:0] lb_wdata_a, lb_wdata_b;
  logic        rd_bank_a, rd_bank_b, busy_a, busy_b, underrun_a, underrun_b;

  ppu_line_fetch_ctrl #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .BASE(BASE_A), .MAX_OUT(MAX_OUT)) dut_a (
    .hdmi_clk(hdmi_clk), .rst(rst), .line_start(line_start), .next_line(next_line),
    .IsGameWindow(IsGameWindow), .mem_req(mem_req_a), .mem_addr(mem_addr_a),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .lb_we(lb_we_a), .lb_waddr(lb_waddr_a), .lb_wdata(lb_wdata_a),
    .rd_bank(rd_bank_a), .busy(busy_a), .underrun(underrun_a));

  ppu_line_fetch_ctrl #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .BASE(BASE_B), .MAX_OUT(MAX_OUT)) dut_b (
    .hdmi_clk(hdmi_clk), .rst(rst), .line_start(line_start), .next_line(next_line),
    .IsGameWindow(IsGameWindow), .mem_req(mem_req_b), .mem_addr(mem_addr_b),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .lb_we(lb_we_b), .lb_waddr(lb_waddr_b), .lb_wdata(lb_wdata_b),
    .rd_bank(rd_bank_b), .busy(busy_b), .underrun(underrun_b));

  typedef struct {
    int          due;
    logic [15:0] data;
  } rd_t;

  typedef struct {
    int line;
    bit game;
    int gnt_pct;
    int lat;       // 0 = random 1..4 cycles
    int abort_at;  // grant count at which a second line_start arrives, -1 none
    int rst_at;    // grant count at which rst is pulsed, -1 none
    bit exp_fetch;
    bit exp_rd;
    bit exp_wb;
  } vec_t;

  rd_t  mq[$];
  vec_t vecs[7];

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int gnt_pct, gnt_force, lat_cfg, first_bank;
  bit checking;

  // Reference model: a fetch is a count of grants and returns against LINE_W.
  bit m_active, m_ready, m_rd, m_wb, m_und;
  int m_line, m_ngr, m_nrc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit exp_req_f();
    return m_active && (m_ngr < LINE_W) && ((m_ngr - m_nrc) < MAX_OUT);
  endfunction

  task automatic check_inst(input string tag, input int base, input logic req,
                            input logic [16:0] addr, input logic we, input logic [8:0] waddr,
                            input logic [15:0] wdata, input logic rdb, input logic bsy,
                            input logic und);
    bit er;
    bit ew;
    er = exp_req_f();
    ew = m_active && mem_rvalid;
    chk({tag, "mem_req"}, 32'(req), 32'(er));
    if (er && req === 1'b1)
      chk({tag, "mem_addr"}, 32'(addr), 32'((base + m_line * LINE_W + m_ngr) % (1 << ADDR_W)));
    chk({tag, "busy"}, 32'(bsy), 32'(m_active));
    chk({tag, "lb_we"}, 32'(we), 32'(ew));
    if (ew) begin
      chk({tag, "lb_waddr"}, 32'(waddr), 32'(m_wb) * 256 + 32'(m_nrc));
      chk({tag, "lb_wdata"}, 32'(wdata), 32'(mem_rdata));
    end
    chk({tag, "underrun"}, 32'(und), 32'(m_und));
    chk({tag, "rd_bank"}, 32'(rdb), 32'(m_rd));
  endtask

  task automatic model_update();
    bit was_active, g, r, st;
    if (rst) begin
      m_active = 0; m_ready = 0; m_rd = 0; m_wb = 0; m_und = 0;
      m_ngr = 0; m_nrc = 0; m_line = 0;
      return;
    end
    was_active = m_active;
    g  = exp_req_f() && mem_gnt;
    r  = m_active && mem_rvalid;
    st = line_start && IsGameWindow;
    m_und = st && was_active;
    if (g) m_ngr++;
    if (r) begin
      m_nrc++;
      if (m_nrc == LINE_W) begin
        m_active = 0;
        m_ready  = 1;
      end
    end
    if (st && !was_active) begin
      if (m_ready) begin
        m_rd    = !m_rd;
        m_ready = 0;
      end
      m_wb     = !m_rd;
      m_line   = int'(next_line);
      m_ngr    = 0;
      m_nrc    = 0;
      m_active = 1;
    end
  endtask

  // One clock: drive memory inputs, check at negedge, update models, step past posedge.
  task automatic do_cycle();
    rd_t e;
    logic grant;
    if (gnt_force >= 0) mem_gnt = gnt_force[0];
    else mem_gnt = ($urandom_range(0, 99) < gnt_pct);
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = mq[0].data;
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = 16'($urandom);
    end
    @(negedge hdmi_clk);
    if (checking) begin
      check_inst("a.", BASE_A, mem_req_a, mem_addr_a, lb_we_a, lb_waddr_a, lb_wdata_a,
                 rd_bank_a, busy_a, underrun_a);
      check_inst("b.", BASE_B, mem_req_b, mem_addr_b, lb_we_b, lb_waddr_b, lb_wdata_b,
                 rd_bank_b, busy_b, underrun_b);
      if (lb_we_a === 1'b1 && first_bank < 0) first_bank = int'(lb_waddr_a[8]);
    end
    grant = mem_req_a && mem_gnt;
    if (mem_rvalid) mq.delete(0);
    if (grant === 1'b1) begin
      e.due  = cyc + ((lat_cfg > 0) ? lat_cfg : int'($urandom_range(1, 4)));
      e.data = 16'($urandom);
      mq.push_back(e);
    end
    if (checking) chk("outstanding_le_max", 32'(mq.size() <= MAX_OUT), 32'd1);
    model_update();
    @(posedge hdmi_clk);
    #1;
    cyc++;
  endtask

  task automatic start_line(input int line, input bit game);
    line_start   = 1'b1;
    next_line    = 9'(line);
    IsGameWindow = game;
    do_cycle();
    line_start   = 1'b0;
    IsGameWindow = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "mem_req"}, 32'(mem_req_a), 32'd0);
    chk({tag, "mem_addr"}, 32'(mem_addr_a), 32'd0);
    chk({tag, "lb_we"}, 32'(lb_we_a), 32'd0);
    chk({tag, "lb_waddr"}, 32'(lb_waddr_a), 32'd0);
    chk({tag, "lb_wdata"}, 32'(lb_wdata_a), 32'd0);
    chk({tag, "rd_bank"}, 32'(rd_bank_a), 32'd0);
    chk({tag, "busy"}, 32'(busy_a), 32'd0);
    chk({tag, "underrun"}, 32'(underrun_a), 32'd0);
  endtask

  // Run until the model's fetch ends and the memory has returned everything.
  task automatic finish_fetch(input int abort_at, input int rst_at, input bit exp_rd);
    int bound;
    bit aborted, did_rst, abort_now, rst_now;
    bound = 0; aborted = 0; did_rst = 0;
    while ((m_active || mq.size() > 0) && bound < 5000) begin
      abort_now = 0;
      rst_now   = 0;
      if (abort_at >= 0 && !aborted && m_active && m_ngr == abort_at) begin
        line_start = 1'b1;
        next_line  = 9'd77;
        aborted    = 1;
        abort_now  = 1;
      end
      if (rst_at >= 0 && !did_rst && m_active && m_ngr == rst_at) begin
        rst     = 1'b1;
        did_rst = 1;
        rst_now = 1;
      end
      do_cycle();
      line_start = 1'b0;
      rst        = 1'b0;
      if (abort_now) begin
        chk("underrun_pulse", 32'(underrun_a), 32'd1);
        chk("abort_rd_bank", 32'(rd_bank_a), 32'(exp_rd));
      end
      if (rst_now) check_reset_outputs("midrst.");
      bound++;
    end
    chk("fetch_done", 32'(m_active || mq.size() > 0), 32'd0);
  endtask

  initial begin
    rst = 1'b1; line_start = 1'b0; next_line = '0; IsGameWindow = 1'b1;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    checking = 0; gnt_force = -1; gnt_pct = 100; lat_cfg = 2; first_bank = -1;

    //           line game pct lat abort rst  fetch rd    wb
    vecs[0] = '{3,   1'b1, 100, 2, -1, -1,  1'b1, 1'b0, 1'b1};
    vecs[1] = '{7,   1'b1, 40,  0, -1, -1,  1'b1, 1'b1, 1'b0};
    vecs[2] = '{20,  1'b1, 60,  0, 50, -1,  1'b1, 1'b0, 1'b1};
    vecs[3] = '{511, 1'b0, 100, 2, -1, -1,  1'b0, 1'b0, 1'b0};
    vecs[4] = '{511, 1'b1, 100, 1, -1, -1,  1'b1, 1'b1, 1'b0};
    vecs[5] = '{100, 1'b1, 80,  3, -1, 100, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{255, 1'b1, 70,  0, -1, -1,  1'b1, 1'b0, 1'b1};

    repeat (3) do_cycle();
    rst = 1'b0;
    checking = 1;
    check_reset_outputs("reset.");

    for (int i = 0; i < 7; i++) begin
      first_bank = -1;
      gnt_force  = -1;
      gnt_pct    = vecs[i].gnt_pct;
      lat_cfg    = vecs[i].lat;
      start_line(vecs[i].line, vecs[i].game);
      chk("entry_rd_bank", 32'(rd_bank_a), 32'(vecs[i].exp_rd));
      chk("entry_busy", 32'(busy_a), 32'(vecs[i].exp_fetch));
      if (vecs[i].exp_fetch) begin
        finish_fetch(vecs[i].abort_at, vecs[i].rst_at, vecs[i].exp_rd);
        chk("entry_wr_bank", 32'(first_bank), 32'(vecs[i].exp_wb));
      end else begin
        repeat (6) do_cycle();
      end
      $display("line %0d game=%0d gnt=%0d%% rd_bank=%0d first_bank=%0d cycles=%0d errors=%0d",
               vecs[i].line, vecs[i].game, vecs[i].gnt_pct, rd_bank_a, first_bank, cyc, n_err);
    end

    // Grant withheld for five cycles, then a non-game line_start while busy.
    first_bank = -1;
    gnt_force  = 0;
    lat_cfg    = 2;
    start_line(9, 1'b1);
    chk("stall_rd_bank", 32'(rd_bank_a), 32'd1);
    for (int k = 0; k < 5; k++) begin
      do_cycle();
      chk("stall_req", 32'(mem_req_a), 32'd1);
      chk("stall_addr", 32'(mem_addr_a), 32'd2304);
    end
    gnt_force    = -1;
    gnt_pct      = 100;
    line_start   = 1'b1;
    IsGameWindow = 1'b0;
    do_cycle();
    line_start   = 1'b0;
    IsGameWindow = 1'b1;
    chk("game0_no_underrun", 32'(underrun_a), 32'd0);
    finish_fetch(-1, -1, 1'b1);
    chk("stall_wr_bank", 32'(first_bank), 32'd0);
    $display("line 9 stall: rd_bank=%0d first_bank=%0d cycles=%0d errors=%0d",
             rd_bank_a, first_bank, cyc, n_err);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
